gcl_gate_ctrl: RTL and testbench
================================

Name: gcl_gate_ctrl

Overview:
- Time-aware gate controller; sits directly upstream of the priority scheduler, which it feeds with an 8-bit per-queue valid vector.
- Steps through a programmable gate control list (GCL); each entry holds an 8-bit gate-open mask and a duration in clock cycles.
- Per-queue valid = gate open AND queue non-empty.
- List is loaded by the local configuration path; cycling is enabled by test start.

Parameters:
DEPTH, 16, number of GCL entries
AW, 4, entry address width (2^AW = DEPTH)
DW, 16, duration field width in cycles

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_gcl_wr_en  input  1  write strobe for one GCL entry
in_gcl_wr_addr  input  AW  entry index to write
in_gcl_wr_gate  input  8  gate-open mask for the entry, bit i = queue i
in_gcl_wr_dur  input  DW  entry duration in cycles; 0 is treated as 1
in_gcl_last_idx  input  AW  index of last active entry; list wraps after it
in_gcl_test_start  input  1  level; high = run the list, low = stop
in_gcl_queue_nempty  input  8  per-queue non-empty flags
out_gcl_valid  output  8  per-queue valid to the scheduler
out_gcl_gate_state  output  8  currently applied gate mask
out_gcl_entry_idx  output  AW  currently applied entry index
out_gcl_cycle_start  output  1  one-cycle pulse each time entry 0 is applied

Behaviour:
- Reset: all outputs 0, FSM in IDLE, remaining counter 0. GCL storage is reset to gate 0 and duration 1 for every entry.
- Writes:
  - When in_gcl_wr_en is high, the entry at in_gcl_wr_addr is written at the clock edge, in any state.
  - A new value takes effect the next time that entry is loaded.
  - A write to the entry being loaded in the same cycle is not seen; read-before-write, so the old value is loaded.
- Effective duration: dur_eff = (dur == 0) ? 1 : dur.
- FSM IDLE:
  - out_gcl_gate_state = 0 and out_gcl_entry_idx = 0.
  - When in_gcl_test_start is sampled high at edge T, the following happen at that edge:
    - state becomes RUN and idx = 0;
    - gate_state = gate[0] and remaining = dur_eff[0];
    - out_gcl_cycle_start = 1 for one cycle.
- FSM RUN, each cycle:
  - If in_gcl_test_start is low, go to IDLE; gate_state, idx and remaining are cleared at that edge. Stop takes priority over advance.
  - Else if remaining == 1, load the next entry:
    - next = (idx >= in_gcl_last_idx) ? 0 : idx+1;
    - gate_state = gate[next], remaining = dur_eff[next];
    - out_gcl_cycle_start = 1 when next == 0.
  - Else remaining decrements by 1.
- Timing consequence: entry k is applied for exactly dur_eff[k] consecutive cycles, and the full list period is the sum of dur_eff[0..last_idx].
- in_gcl_last_idx is sampled only at the wrap decision. Lowering it below the current idx makes the list wrap to 0 at the end of the current entry.
- Valid output:
  - out_gcl_valid = out_gcl_gate_state & in_gcl_queue_nempty, combinational from a registered mask with no added latency.
  - It is 0 whenever in IDLE.
- out_gcl_cycle_start is registered and otherwise 0.
- Reset asserted mid-run: immediate return to reset values and IDLE. Storage contents after reset are the reset values.
- Restart: after a stop, a new rising of test start always begins at entry 0.

Test Plan:
- Reset then program entries 0,1,2 with gate 0x01/0x02/0x80 and dur 4/2/3, last_idx = 2, hold test_start and nempty = 0xFF:
  - gate_state is 0x01 for 4 cycles, 0x02 for 2 cycles, 0x80 for 3 cycles, repeating with period 9;
  - cycle_start pulses every 9 cycles, aligned with the first 0x01 cycle.
- Entry 1 dur = 0, same list:
  - entry 1 is applied for exactly 1 cycle and the period is 8.
- nempty = 0x81 during the 3-entry run:
  - out_gcl_valid is 0x01, then 0x00, then 0x80 in the respective windows.
- During the run, write entry 2 gate 0x40 while entry 0 is applied:
  - the next entry-2 window shows 0x40.
  - Writing entry 1 on the exact cycle it is loaded makes it show the old mask for that window and the new mask one period later.
- Drop test_start in the middle of entry 1:
  - next cycle gate_state, idx and valid are 0.
  - Re-assert test_start: entry 0 is applied for its full 4 cycles and cycle_start pulses.
- Assert rst_n low mid-run for 1 cycle:
  - outputs are immediately 0;
  - gates stay 0 after restart until the list is reprogrammed, since storage is reset to gate 0.

Source files
------------

// File: rtl/gcl_gate_ctrl.sv
// gcl_gate_ctrl
//   Time-aware gate controller. Steps through a programmable gate control
//   list (GCL); each entry holds an 8-bit gate-open mask and a duration in
//   clock cycles. The applied mask is ANDed with the queue non-empty flags
//   to form the per-queue valid vector for the downstream scheduler.
//
// Ports
//   clk                  system clock
//   rst_n                asynchronous active-low reset
//   in_gcl_wr_en         write strobe for one GCL entry
//   in_gcl_wr_addr       entry index to write
//   in_gcl_wr_gate       gate-open mask for the entry (bit i = queue i)
//   in_gcl_wr_dur        entry duration in cycles (0 behaves as 1)
//   in_gcl_last_idx      index of last active entry; list wraps after it
//   in_gcl_test_start    level: high = run the list, low = stop
//   in_gcl_queue_nempty  per-queue non-empty flags
//   out_gcl_valid        per-queue valid to the scheduler
//   out_gcl_gate_state   currently applied gate mask
//   out_gcl_entry_idx    currently applied entry index
//   out_gcl_cycle_start  one-cycle pulse each time entry 0 is applied
module gcl_gate_ctrl #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned DW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_gcl_wr_en,
   input  logic [AW-1:0] in_gcl_wr_addr,
   input  logic [7:0]    in_gcl_wr_gate,
   input  logic [DW-1:0] in_gcl_wr_dur,
   input  logic [AW-1:0] in_gcl_last_idx,
   input  logic          in_gcl_test_start,
   input  logic [7:0]    in_gcl_queue_nempty,
   output logic [7:0]    out_gcl_valid,
   output logic [7:0]    out_gcl_gate_state,
   output logic [AW-1:0] out_gcl_entry_idx,
   output logic          out_gcl_cycle_start
);

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [7:0]    r_gate [DEPTH];
   logic [DW-1:0] r_dur  [DEPTH];
   logic [7:0]    r_gate_state, w_gate_state_nxt;
   logic [AW-1:0] r_idx, w_idx_nxt;
   logic [DW-1:0] r_rem, w_rem_nxt;
   logic          r_cstart, w_cstart_nxt;
   logic          w_load;
   logic [AW-1:0] w_load_idx;
   logic [DW-1:0] w_load_dur;

   // GCL storage. Loads read the pre-edge contents, so a write to the entry
   // being loaded on the same edge only shows up on its next load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_gate[i] <= '0;
            r_dur[i]  <= DW'(1);
         end
      end else if (in_gcl_wr_en) begin
         r_gate[in_gcl_wr_addr] <= in_gcl_wr_gate;
         r_dur[in_gcl_wr_addr]  <= in_gcl_wr_dur;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_gate_state <= '0;
         r_idx        <= '0;
         r_rem        <= '0;
         r_cstart     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_gate_state <= w_gate_state_nxt;
         r_idx        <= w_idx_nxt;
         r_rem        <= w_rem_nxt;
         r_cstart     <= w_cstart_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_gate_state_nxt = r_gate_state;
      w_idx_nxt        = r_idx;
      w_rem_nxt        = r_rem;
      w_cstart_nxt     = 1'b0;
      w_load           = 1'b0;
      w_load_idx       = '0;
      w_load_dur       = '0;

      case (r_state)
         ST_IDLE: begin
            if (in_gcl_test_start) begin
               w_state_nxt = ST_RUN;
               w_load      = 1'b1;
            end
         end
         ST_RUN: begin
            // Stop wins over advancing to the next entry.
            if (!in_gcl_test_start) begin
               w_state_nxt      = ST_IDLE;
               w_gate_state_nxt = '0;
               w_idx_nxt        = '0;
               w_rem_nxt        = '0;
            end else if (r_rem == DW'(1)) begin
               w_load     = 1'b1;
               w_load_idx = (r_idx >= in_gcl_last_idx) ? '0 : r_idx + AW'(1);
            end else begin
               w_rem_nxt = r_rem - DW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (w_load) begin
         w_load_dur       = r_dur[w_load_idx];
         w_idx_nxt        = w_load_idx;
         w_gate_state_nxt = r_gate[w_load_idx];
         w_rem_nxt        = (w_load_dur == '0) ? DW'(1) : w_load_dur;
         w_cstart_nxt     = (w_load_idx == '0);
      end
   end

   // Gate state is held at zero while idle, so valid is zero there too.
   assign out_gcl_valid       = r_gate_state & in_gcl_queue_nempty;
   assign out_gcl_gate_state  = r_gate_state;
   assign out_gcl_entry_idx   = r_idx;
   assign out_gcl_cycle_start = r_cstart;

endmodule

// File: tb/tb_gcl_gate_ctrl.sv
// tb_gcl_gate_ctrl
//   Bench for gcl_gate_ctrl. A behavioural reference model tracks which
//   entry is applied and how many cycles it has been shown, and is compared
//   against every DUT output each cycle, followed by a randomized phase.
module tb_gcl_gate_ctrl;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_gate;
   logic [DW-1:0] wr_dur;
   logic [AW-1:0] last_idx;
   logic          test_start;
   logic [7:0]    nempty;
   logic [7:0]    o_valid;
   logic [7:0]    o_gate_state;
   logic [AW-1:0] o_idx;
   logic          o_cstart;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   // Reference model state
   logic [7:0]  m_gate [DEPTH];
   int unsigned m_dur  [DEPTH];
   bit          m_run;
   int unsigned m_idx;
   int unsigned m_age;   // cycles the current entry has been shown so far
   int unsigned m_len;   // effective length captured when the entry loaded
   logic [7:0]  m_gst;
   bit          m_cs;

   gcl_gate_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .in_gcl_wr_en        (wr_en),
      .in_gcl_wr_addr      (wr_addr),
      .in_gcl_wr_gate      (wr_gate),
      .in_gcl_wr_dur       (wr_dur),
      .in_gcl_last_idx     (last_idx),
      .in_gcl_test_start   (test_start),
      .in_gcl_queue_nempty (nempty),
      .out_gcl_valid       (o_valid),
      .out_gcl_gate_state  (o_gate_state),
      .out_gcl_entry_idx   (o_idx),
      .out_gcl_cycle_start (o_cstart)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_gate[i] = 8'h00;
         m_dur[i]  = 1;
      end
      m_run = 0;
      m_idx = 0;
      m_age = 0;
      m_len = 0;
      m_gst = 8'h00;
      m_cs  = 0;
   endfunction

   function automatic void model_load(input int unsigned n);
      m_idx = n;
      m_gst = m_gate[n];
      m_len = (m_dur[n] == 0) ? 1 : m_dur[n];
      m_age = 1;
      m_cs  = (n == 0);
   endfunction

   // One clock edge of the reference: schedule first, then storage write.
   function automatic void model_edge();
      m_cs = 0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (!m_run) begin
         if (test_start) begin
            m_run = 1;
            model_load(0);
         end
      end else if (!test_start) begin
         m_run = 0;
      end else if (m_age >= m_len) begin
         model_load((m_idx >= int'(last_idx)) ? 0 : m_idx + 1);
      end else begin
         m_age++;
      end
      if (wr_en) begin
         m_gate[wr_addr] = wr_gate;
         m_dur[wr_addr]  = int'(wr_dur);
      end
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_all();
      logic [7:0] exp_gst;
      exp_gst = m_run ? m_gst : 8'h00;
      check("gate_state",  16'(o_gate_state), 16'(exp_gst));
      check("entry_idx",   16'(o_idx),        m_run ? 16'(m_idx) : 16'd0);
      check("cycle_start", 16'(o_cstart),     16'(m_cs));
      check("valid",       16'(o_valid),      16'(exp_gst & nempty));
   endtask

   // Edge, model update, check, then return at the negedge to drive inputs.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   task automatic write_entry(input int unsigned a, input logic [7:0] g, input int unsigned d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_gate = g;
      wr_dur  = DW'(d);
      tick();
      wr_en   = 1'b0;
   endtask

   // Cycles between consecutive cycle_start pulses.
   task automatic measure_period(input int unsigned exp_period);
      int unsigned n = 0;
      while (!o_cstart && n < 64) begin
         tick();
         n++;
      end
      if (!o_cstart) begin
         check("period_sync_timeout", 16'(o_cstart), 16'd1);
         return;
      end
      n = 0;
      do begin
         tick();
         n++;
      end while (!o_cstart && n < 64);
      check("period", 16'(n), 16'(exp_period));
   endtask

   task automatic wait_entry(input int unsigned e);
      int unsigned n = 0;
      while (!(m_run && m_idx == e) && n < 64) begin
         tick();
         n++;
      end
      check("wait_entry_timeout", 16'(o_idx), 16'(e));
   endtask

   initial begin
      int unsigned sum;
      bit          done;

      rst_n      = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_gate    = '0;
      wr_dur     = '0;
      last_idx   = '0;
      test_start = 1'b0;
      nempty     = 8'hFF;
      model_reset();
      @(negedge clk);
      #1;
      check_all();
      tick();
      rst_n = 1'b1;
      run(2);

      // Three-entry list: 0x01/4, 0x02/2, 0x80/3
      write_entry(0, 8'h01, 4);
      write_entry(1, 8'h02, 2);
      write_entry(2, 8'h80, 3);
      last_idx   = AW'(2);
      test_start = 1'b1;
      run(20);
      measure_period(4 + 2 + 3);

      // Masked by queue occupancy
      nempty = 8'h81;
      run(18);
      nempty = 8'hFF;

      // Rewrite entry 2 while entry 0 is applied
      wait_entry(0);
      write_entry(2, 8'h40, 3);
      run(20);

      // Write entry 1 on the very edge it gets loaded
      done = 0;
      for (int unsigned i = 0; i < 40; i++) begin
         if (!done && m_run && m_idx == 0 && m_age == m_len) begin
            wr_en   = 1'b1;
            wr_addr = AW'(1);
            wr_gate = 8'h20;
            wr_dur  = DW'(2);
            done    = 1;
         end
         tick();
         wr_en = 1'b0;
      end
      check("write_on_load_seen", 16'(done), 16'd1);

      // Zero duration behaves as one cycle
      write_entry(1, 8'h02, 0);
      run(10);
      sum = 0;
      for (int unsigned i = 0; i <= 2; i++) sum += (m_dur[i] == 0) ? 1 : m_dur[i];
      measure_period(sum);

      // Stop in the middle of entry 1 and restart
      write_entry(1, 8'h02, 2);
      run(12);
      wait_entry(1);
      test_start = 1'b0;
      tick();
      run(3);
      test_start = 1'b1;
      run(12);

      // Asynchronous reset mid-run
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      tick();
      rst_n = 1'b1;
      run(12);
      test_start = 1'b0;
      run(2);

      // Randomized phase
      for (int unsigned i = 0; i < 6; i++) write_entry(i, 8'($urandom), $urandom_range(0, 5));
      last_idx   = AW'(5);
      test_start = 1'b1;
      for (int unsigned i = 0; i < 1500; i++) begin
         nempty = 8'($urandom);
         wr_en  = ($urandom_range(0, 3) == 0);
         wr_addr = AW'($urandom_range(0, DEPTH - 1));
         wr_gate = 8'($urandom);
         wr_dur  = DW'($urandom_range(0, 6));
         if ($urandom_range(0, 49) == 0) last_idx = AW'($urandom_range(0, DEPTH - 1));
         if ($urandom_range(0, 99) == 0) test_start = ~test_start;
         tick();
      end
      wr_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
